// File: rtl/button_debouncer.sv
// button_debouncer: multi-channel push-button debouncer.
// Each channel runs a two-flop synchroniser and a stability counter clocked
// by a shared sample strobe. The debounced level flips only after THRESH
// consecutive strobes disagree with it. A flip emits a one-cycle rise or
// fall pulse.
// Optional feature, enabled by defining DEBOUNCE_STICKY_EN: a per-channel
// sticky "held" flag is set by rise and cleared by clear. When the macro is
// undefined, held is tied to 0 and clear is ignored.

module button_debouncer #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 4,
  parameter int THRESH   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] held
);

  // The prescaler is at least one bit wide. With TICK_DIV=1 it sits at 0,
  // which equals PRE_LAST, so the strobe stays high.
  localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

  // Reject illegal parameter sets at elaboration.
  if (THRESH < 1 || THRESH > (1 << CNT_W)) begin : g_bad_thresh
    $error("button_debouncer: THRESH must be in 1..2**CNT_W");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("button_debouncer: TICK_DIV must be >= 1");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("button_debouncer: CHANNELS must be in 1..16");
  end

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [PRE_W-1:0]    pre_cnt;
  logic                strobe;

  logic [CNT_W-1:0]    cnt      [CHANNELS];
  logic [CNT_W-1:0]    cnt_next [CHANNELS];
  logic [CHANNELS-1:0] level_next;
  logic [CHANNELS-1:0] rise_next;
  logic [CHANNELS-1:0] fall_next;

  // Two-flop synchroniser that brings the asynchronous pins into the clock domain.
  // NOTE: Sequential state uses non-blocking assignments so that every flop
  // samples pre-edge values. A blocking assignment here would merge s1 and s2
  // into a single stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Shared prescaler that counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  assign strobe = (pre_cnt == PRE_LAST);

  // Per-channel stability decision: restart on agreement, flip after THRESH disagreements.
  // NOTE: Every signal written here gets its default first. The branches can
  // then leave outputs unassigned without inferring latches.
  always_comb begin
    cnt_next   = cnt;
    level_next = level;
    rise_next  = '0;
    fall_next  = '0;
    if (strobe) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (s2[i] == level[i]) begin
          cnt_next[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          level_next[i] = s2[i];
          cnt_next[i]   = '0;
          rise_next[i]  = s2[i];
          fall_next[i]  = ~s2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Register level, pulses and counters so that rise/fall line up with the new level.
  // NOTE: The per-channel counter array is a small register file, not RAM. It
  // is reset explicitly, so a partial count from before reset can never shorten
  // the first debounce after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      level <= level_next;
      rise  <= rise_next;
      fall  <= fall_next;
      cnt   <= cnt_next;
    end
  end

`ifdef DEBOUNCE_STICKY_EN
  // Sticky press flag: set by a visible rise pulse, cleared by clear; set wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held <= '0;
    end else begin
      held <= (held & ~clear) | rise;
    end
  end
`else
  // No sticky flags are built; clear is deliberately left unused.
  logic unused_clear;
  assign unused_clear = ^clear;
  assign held         = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: self-checking bench for button_debouncer.
// Two instances are built: A with the defaults (TICK_DIV=1), and B with
// TICK_DIV=8. Both run in lockstep against a reference model. The model keeps
// a history of strobe samples per channel and flips the level when the last
// THRESH samples all disagree with it.

module tb_button_debouncer;

  localparam int CH   = 2;
  localparam int THR  = 4;
  localparam int TD_A = 1;
  localparam int TD_B = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] raw_v = '0;
  logic [CH-1:0] clr_v = '0;

  logic [CH-1:0] level_a, rise_a, fall_a, held_a;
  logic [CH-1:0] level_b, rise_b, fall_b, held_b;

  int errors = 0;
  int checks = 0;

  button_debouncer #(.CHANNELS(CH), .CNT_W(4), .THRESH(THR), .TICK_DIV(TD_A)) dut_a (
    .clock(clock), .reset(reset), .raw_in(raw_v), .clear(clr_v),
    .level(level_a), .rise(rise_a), .fall(fall_a), .held(held_a)
  );

  button_debouncer #(.CHANNELS(CH), .CNT_W(4), .THRESH(THR), .TICK_DIV(TD_B)) dut_b (
    .clock(clock), .reset(reset), .raw_in(raw_v), .clear(clr_v),
    .level(level_b), .rise(rise_b), .fall(fall_b), .held(held_b)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [CH-1:0] m_s1   [2];
  bit [CH-1:0] m_s2   [2];
  bit [CH-1:0] m_lvl  [2];
  bit [CH-1:0] m_rise [2];
  bit [CH-1:0] m_fall [2];
  bit [CH-1:0] m_held [2];
  int unsigned m_hist [2][CH];
  int          m_ecnt [2];

  function automatic int td_of(input int i);
    return (i == 0) ? TD_A : TD_B;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = '0; m_s2[i] = '0; m_lvl[i] = '0;
      m_rise[i] = '0; m_fall[i] = '0; m_held[i] = '0;
      m_ecnt[i] = 0;
      for (int c = 0; c < CH; c++) m_hist[i][c] = 0;
    end
  endtask

  // Advance the model by one rising edge, using the pre-edge inputs.
  task automatic model_edge();
    int unsigned mask;
    mask = (32'd1 << THR) - 32'd1;
    for (int i = 0; i < 2; i++) begin
      bit          strobe;
      bit [CH-1:0] n_lvl;
      bit [CH-1:0] n_rise;
      bit [CH-1:0] n_fall;
      strobe = ((m_ecnt[i] % td_of(i)) == td_of(i) - 1);
      n_lvl  = m_lvl[i];
      n_rise = '0;
      n_fall = '0;
      if (strobe) begin
        for (int c = 0; c < CH; c++) begin
          m_hist[i][c] = (m_hist[i][c] << 1) | {31'b0, m_s2[i][c]};
          if ((m_hist[i][c] & mask) == (m_lvl[i][c] ? 32'd0 : mask)) begin
            n_lvl[c]  = m_s2[i][c];
            n_rise[c] = m_s2[i][c];
            n_fall[c] = ~m_s2[i][c];
          end
        end
      end
`ifdef DEBOUNCE_STICKY_EN
      m_held[i] = (m_held[i] & ~clr_v) | m_rise[i];
`else
      m_held[i] = '0;
`endif
      m_lvl[i]  = n_lvl;
      m_rise[i] = n_rise;
      m_fall[i] = n_fall;
      m_s2[i]   = m_s1[i];
      m_s1[i]   = raw_v;
      m_ecnt[i]++;
    end
  endtask

  task automatic compare_model();
    check("model_level_a", 16'(level_a), 16'(m_lvl[0]));
    check("model_rise_a",  16'(rise_a),  16'(m_rise[0]));
    check("model_fall_a",  16'(fall_a),  16'(m_fall[0]));
    check("model_held_a",  16'(held_a),  16'(m_held[0]));
    check("model_level_b", 16'(level_b), 16'(m_lvl[1]));
    check("model_rise_b",  16'(rise_b),  16'(m_rise[1]));
    check("model_fall_b",  16'(fall_b),  16'(m_fall[1]));
    check("model_held_b",  16'(held_b),  16'(m_held[1]));
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_model();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Hold reset across one rising edge; all outputs must read 0.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    check("rst_level_a", 16'(level_a), 16'h0);
    check("rst_rise_a",  16'(rise_a),  16'h0);
    check("rst_fall_a",  16'(fall_a),  16'h0);
    check("rst_held_a",  16'(held_a),  16'h0);
    check("rst_level_b", 16'(level_b), 16'h0);
    check("rst_held_b",  16'(held_b),  16'h0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [CH-1:0] raw;
    logic [CH-1:0] lvl;
    logic [CH-1:0] rs;
    logic [CH-1:0] fl;
  } vec_t;

  initial begin
    vec_t vecs[16];
    int   lat;
    int   n;

    // Clean press then release on channel 0. Row k is checked after edge k+1
    // following reset: the press is sampled at edge 1 and takes effect at edge
    // 6; the release is sampled at edge 9 and takes effect at edge 14.
    vecs = '{
      '{raw:2'b01, lvl:2'b00, rs:2'b00, fl:2'b00},
      '{raw:2'b01, lvl:2'b00, rs:2'b00, fl:2'b00},
      '{raw:2'b01, lvl:2'b00, rs:2'b00, fl:2'b00},
      '{raw:2'b01, lvl:2'b00, rs:2'b00, fl:2'b00},
      '{raw:2'b01, lvl:2'b00, rs:2'b00, fl:2'b00},
      '{raw:2'b01, lvl:2'b01, rs:2'b01, fl:2'b00},
      '{raw:2'b01, lvl:2'b01, rs:2'b00, fl:2'b00},
      '{raw:2'b01, lvl:2'b01, rs:2'b00, fl:2'b00},
      '{raw:2'b00, lvl:2'b01, rs:2'b00, fl:2'b00},
      '{raw:2'b00, lvl:2'b01, rs:2'b00, fl:2'b00},
      '{raw:2'b00, lvl:2'b01, rs:2'b00, fl:2'b00},
      '{raw:2'b00, lvl:2'b01, rs:2'b00, fl:2'b00},
      '{raw:2'b00, lvl:2'b01, rs:2'b00, fl:2'b00},
      '{raw:2'b00, lvl:2'b00, rs:2'b00, fl:2'b01},
      '{raw:2'b00, lvl:2'b00, rs:2'b00, fl:2'b00},
      '{raw:2'b00, lvl:2'b00, rs:2'b00, fl:2'b00}
    };

    do_reset();
    for (int k = 0; k < 16; k++) begin
      raw_v = vecs[k].raw;
      step();
      check("vec_level", 16'(level_a), 16'(vecs[k].lvl));
      check("vec_rise",  16'(rise_a),  16'(vecs[k].rs));
      check("vec_fall",  16'(fall_a),  16'(vecs[k].fl));
    end

    // Bounce on channel 1 (1,0,1,0 then quiet): it must never produce a level change or pulse.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      raw_v = {((k < 4) && (k % 2 == 0)) ? 1'b1 : 1'b0, 1'b0};
      step();
      check("bounce_level1", 16'(level_a[1]), 16'h0);
      check("bounce_rise1",  16'(rise_a[1]),  16'h0);
      check("bounce_fall1",  16'(fall_a[1]),  16'h0);
    end

    // Both channels are held high, then dropped together: fall=11 exactly once, 6 clocks after the drop.
    do_reset();
    raw_v = 2'b11;
    steps(20);
    check("dual_level_high", 16'(level_a), 16'h3);
    raw_v = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("dual_fall", 16'(fall_a), (k == 6) ? 16'h3 : 16'h0);
    end

    // Reset mid-count: the partial count is discarded, so the full latency applies again.
    do_reset();
    raw_v = 2'b01;
    steps(3);
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      step();
      check("rstmid_level0", 16'(level_a[0]), (k == 6) ? 16'h1 : 16'h0);
    end

    // Prescaler: the level on B must appear within the synchroniser plus THRESH strobe windows.
    // The earliest case is when the first counted strobe arrives right after the synchroniser fills.
    do_reset();
    raw_v = 2'b01;
    lat = 0;
    while (level_b[0] == 1'b0 && lat < 100) begin
      step();
      lat++;
    end
    check("presc_latency_window", 16'((lat >= 2 + (THR - 1) * TD_B + 1) && (lat <= 2 + THR * TD_B + TD_B - 1)), 16'h1);

    // Prescaler: a 20-clock pulse covers at most 3 strobes, so B must reject it.
    do_reset();
    raw_v = 2'b01;
    steps(20);
    raw_v = 2'b00;
    for (int k = 0; k < 60; k++) begin
      step();
      check("presc_reject_level", 16'(level_b[0]), 16'h0);
      check("presc_reject_rise",  16'(rise_b[0]),  16'h0);
    end

`ifdef DEBOUNCE_STICKY_EN
    // Sticky flag: set after a press, kept after release, dropped by clear.
    do_reset();
    raw_v = 2'b01;
    steps(7);
    check("sticky_set", 16'(held_a[0]), 16'h1);
    raw_v = 2'b00;
    steps(12);
    check("sticky_persist", 16'(held_a[0]), 16'h1);
    clr_v = 2'b01;
    step();
    clr_v = 2'b00;
    check("sticky_clear", 16'(held_a[0]), 16'h0);

    // A clear that coincides with the rise pulse loses, because set wins.
    do_reset();
    raw_v = 2'b01;
    n = 0;
    while (rise_a[0] == 1'b0 && n < 20) begin
      step();
      n++;
    end
    check("sticky_rise_seen", 16'(rise_a[0]), 16'h1);
    clr_v = 2'b01;
    step();
    clr_v = 2'b00;
    check("sticky_set_wins", 16'(held_a[0]), 16'h1);
`else
    // Without the sticky feature, held stays 0 through a press and clear traffic.
    do_reset();
    raw_v = 2'b11;
    clr_v = 2'b10;
    steps(10);
    clr_v = 2'b00;
    check("held_tied_low", 16'(held_a), 16'h0);
    n = 0;
`endif

    // Randomised traffic: first with fast toggles, then with slow ones so that B flips too.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 9) == 0) raw_v[c] = ~raw_v[c];
      clr_v = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      step();
    end
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 39) == 0) raw_v[c] = ~raw_v[c];
      clr_v = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
